// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO on a valid/ready input feeding a
// start/data/stop serializer that chains frames back-to-back while bytes remain.
module uart_tx_fifo #(
  parameter int DELAY_FRAMES = 234,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         uart_tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DELAY_FRAMES);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DELAY_FRAMES - 1);
  localparam logic [PW:0]   COUNT_FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic [2:0]    bitIdx, bitIdxNext;
  logic [7:0]    shifter;
  logic          txNext;
  logic          push, pop;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;

  // Readiness comes from the registered count only, so a full FIFO refuses a
  // push even on the edge where the serializer pops.
  assign in_ready = (fifo_count != COUNT_FULL);
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE) || (fifo_count != '0);

  // uart_tx is registered: txNext is the level belonging to the next state.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    bitIdxNext = bitIdx;
    txNext     = uart_tx;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        txNext = 1'b1;
        if (fifo_count != '0) begin
          pop        = 1'b1;
          cntNext    = '0;
          bitIdxNext = '0;
          stateNext  = START;
          txNext     = 1'b0;
        end
      end
      START: begin
        if (cnt == CNT_LAST) begin
          cntNext    = '0;
          bitIdxNext = '0;
          stateNext  = DATA;
          txNext     = shifter[0];
        end else begin
          cntNext = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cntNext = '0;
          if (bitIdx == 3'd7) begin
            stateNext = STOP;
            txNext    = 1'b1;
          end else begin
            bitIdxNext = bitIdx + 3'd1;
            txNext     = shifter[bitIdxNext];
          end
        end else begin
          cntNext = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cntNext = '0;
          if (fifo_count != '0) begin
            pop        = 1'b1;
            bitIdxNext = '0;
            stateNext  = START;
            txNext     = 1'b0;
          end else begin
            stateNext = IDLE;
            txNext    = 1'b1;
          end
        end else begin
          cntNext = cnt + CW'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        txNext    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bitIdx     <= '0;
      uart_tx    <= 1'b1;
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      bitIdx  <= bitIdxNext;
      uart_tx <= txNext;
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage and shifter carry no reset; the control pointers decide validity.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= in_data;
    if (pop)  shifter    <= mem[rdPtr];
  end

endmodule
